// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: captures rs1/rs2/funct3/rd, iterates one
// bit per cycle, then emits a one-cycle register-file write strobe with the result.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [XLEN-1:0] mag_a, mag_b, acc_hi, acc_lo;
  logic            neg_res, neg_rem;
  logic [4:0]      rd_cap;

  // Operand decode at acceptance
  logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c;
  logic            div_zero_c, div_ovf_c, special_c, accept_c;
  logic [XLEN-1:0] special_val_c;

  assign a_signed_c = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed_c = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg_c    = a_signed_c & a_in[XLEN-1];
  assign b_neg_c    = b_signed_c & b_in[XLEN-1];
  assign div_zero_c = funct3[2] && (b_in == '0);
  assign div_ovf_c  = funct3[2] && !funct3[0] && (b_in == '1) &&
                      (a_in == {1'b1, {(XLEN-1){1'b0}}});
  assign special_c  = div_zero_c || div_ovf_c;
  assign special_val_c = div_zero_c ? (funct3[1] ? a_in : '1)
                                    : (funct3[1] ? '0 : a_in);
  assign accept_c   = (state == IDLE) && !busy && start;

  // One iteration: shift-add for multiply, restore-subtract for divide
  logic [XLEN:0]   mul_sum_c, div_shift_c, div_diff_c;
  logic            div_ge_c;

  assign mul_sum_c   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
  assign div_shift_c = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff_c  = div_shift_c - {1'b0, mag_b};
  assign div_ge_c    = !div_diff_c[XLEN];

  // Sign correction and word selection
  logic [PW-1:0]   prod_c;
  logic [XLEN-1:0] quo_c, rem_c, fix_val_c;

  always_comb begin
    prod_c = neg_res ? (PW'(0) - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    quo_c  = neg_res ? (XLEN'(0) - acc_lo) : acc_lo;
    rem_c  = neg_rem ? (XLEN'(0) - acc_hi) : acc_hi;
    if (op[2])
      fix_val_c = op[1] ? rem_c : quo_c;
    else
      fix_val_c = (op[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_c) state_next = special_c ? DONE : CALC;
      CALC: if (cnt == CW'(XLEN - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath control decode
  logic busy_next, done_next, step_c, fix_c;

  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    step_c    = 1'b0;
    fix_c     = 1'b0;
    case (state)
      CALC:    begin busy_next = 1'b1; step_c = 1'b1; end
      FIX:     begin busy_next = 1'b1; fix_c  = 1'b1; end
      DONE:    begin busy_next = 1'b1; done_next = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
      cnt     <= '0;
      op      <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      rd_cap  <= '0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (accept_c) begin
        op      <= funct3;
        mag_a   <= a_neg_c ? (XLEN'(0) - a_in) : a_in;
        mag_b   <= b_neg_c ? (XLEN'(0) - b_in) : b_in;
        neg_res <= a_neg_c ^ b_neg_c;
        neg_rem <= a_neg_c;
        rd_cap  <= rd_in;
        cnt     <= '0;
        acc_hi  <= '0;
        // Multiplier (mul) or dividend (div) streams through the low word
        if (funct3[2]) acc_lo <= a_neg_c ? (XLEN'(0) - a_in) : a_in;
        else           acc_lo <= b_neg_c ? (XLEN'(0) - b_in) : b_in;
        if (special_c) begin
          result <= special_val_c;
          rd_out <= rd_in;
        end
      end
      if (step_c) begin
        cnt <= cnt + CW'(1);
        if (op[2]) begin
          acc_hi <= div_ge_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], div_ge_c};
        end else begin
          {acc_hi, acc_lo} <= {mul_sum_c, acc_lo[XLEN-1:1]};
        end
      end
      if (fix_c) begin
        result <= fix_val_c;
        rd_out <= rd_cap;
      end
    end
  end

endmodule
